cr_huf_comp_sc_long_xmt: RTL and testbench
==========================================

// Module: cr_huf_comp_sc_long_xmt
// PURPOSE
//  Transmit end of the symbol-count -> insertion-sort "long" interface. Accumulates per-symbol
//  frequencies for one block of long (length/distance) symbols, then streams every nonzero
//  (symbol, count) pair to the insertion sort over sc_is_long_vld / is_sc_long_rd, tagged with
//  seq_id, and flags the block's last pair with eob. Sits between LZ symbol decode and the long insertion sort.
// PARAMETERS
//  DAT_WIDTH    10   symbol index width (CREOLE_HC_LONG_DAT_WIDTH)
//  CNT_WIDTH    16   per-symbol count width (CREOLE_HC_LONG_CNT_WIDTH)
//  NUM_SYM      576  symbols in alphabet; table depth; must be <= 2**DAT_WIDTH
//  SEQID_WIDTH  8    block sequence id width (CREOLE_HC_SEQID_WIDTH)
// PORTS
//  clk              in   1            clock
//  rst              in   1            async reset, active high
//  sym_vld          in   1            symbol occurrence valid (accepted when sym_rdy)
//  sym              in   DAT_WIDTH    symbol index; values >= NUM_SYM ignored, not counted
//  blk_end          in   1            closes block (qualified by sym_rdy; may coincide with sym_vld)
//  blk_seq_id       in   SEQID_WIDTH  sequence id of the block, sampled with blk_end
//  sym_rdy          out  1            1 only in COUNT
//  is_sc_long_rd    in   1            sort consumed current pair (transfer = vld & rd)
//  sc_is_long_vld   out  1            pair valid
//  sc_is_long_intf  out  struct       s_sc_is_long_intf {long, cnt, seq_id, eob}
//  blk_busy         out  1            1 from reset release / blk_end until last pair transferred
// BEHAVIOUR
//  Reset: sym_rdy=0, sc_is_long_vld=0, intf all-zero, blk_busy=1, FSM=CLEAR, scan ptr=0.
//  FSM CLEAR: write 0 to entry ptr each cycle; ptr==NUM_SYM-1 -> COUNT, blk_busy=0.
//  COUNT: sym_rdy=1. sym_vld: read-modify-write entry sym, count saturates at 2**CNT_WIDTH-1.
//   1-cycle RMW pipe; back-to-back same symbol forwarded from pipe (no lost increments).
//   blk_end: symbol on same cycle is counted first; latch seq_id; blk_busy=1; ptr=0 -> SCAN
//   (SCAN starts after RMW pipe has drained).
//  SCAN: read entry ptr (1-cycle read latency), clear-on-read writes 0 back. Nonzero -> load
//   output reg {long=ptr, cnt, seq_id, eob=0} -> HOLD. Zero -> ptr++. Hold-back: a nonzero pair
//   is presented only once the next nonzero entry is found or ptr passes NUM_SYM-1, so eob is
//   known when the pair is presented.
//  HOLD: vld=1, intf stable until transfer. On transfer, resume SCAN (or EOB_OUT if table exhausted).
//  eob=1 on the final nonzero pair. Empty block (all counts 0): emit one pair
//   {long=0, cnt=0, seq_id, eob=1}. After eob transfer: blk_busy=0 -> COUNT. Table already zero
//   via clear-on-read, so no CLEAR pass is needed between blocks.
//  rd without vld: ignored. vld never drops without a transfer. Throughput: at most 1 pair per
//   2 cycles when entries are dense.
//  Async reset mid-block: block discarded, vld drops immediately, full CLEAR pass (NUM_SYM cycles).
// STRUCTURE
//  cr_huf_compPKG: s_sc_is_long_intf (existing), FSM enum e_sc_long_xmt_st {CLEAR, COUNT, SCAN,
//   HOLD, EOB_OUT}.
//  Width constants come from cr_huf_comp.vh.
//  Sub-module cr_huf_comp_sc_long_cnt_ram: NUM_SYM x CNT_WIDTH, 1R1W, 1-cycle read, write-first.
//  Top: FSM, RMW/forwarding pipe, scan pointer, hold-back output register.
// TESTING
//  1. Syms 3,3,7 then blk_end seq=5 -> pairs (3,2,eob0),(7,1,eob1), both seq_id 5.
//  2. Sym 9 x (2**CNT_WIDTH+4) -> single pair (9,65535,eob1).
//  3. blk_end with no syms, seq=2 -> one pair (0,0,seq 2,eob1).
//  4. rd held low 20 cycles during HOLD -> vld/intf stable; next block counts from zero.
//  5. Syms 0 and NUM_SYM-1, rd always 1 -> pairs 0 then 575(eob); sym=600 is not counted.
//  6. rst pulse mid-HOLD -> vld=0 async; sym_rdy=1 after NUM_SYM cycles; old counts gone.

Source files
------------

// File: rtl/cr_huf_comp_sc_long_xmt_pkg.sv
// ============================================================================
//  Module      : cr_huf_comp_sc_long_xmt_pkg
//  Description : Shared widths, long-interface payload struct and FSM states
//                for the symbol-count -> long insertion-sort transmit path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cr_huf_comp_sc_long_xmt_pkg;

    localparam int CR_HC_LONG_DAT_WIDTH = 10;
    localparam int CR_HC_LONG_CNT_WIDTH = 16;
    localparam int CR_HC_LONG_NUM_SYM   = 576;
    localparam int CR_HC_SEQID_WIDTH    = 8;

    typedef struct packed {
        logic [CR_HC_LONG_DAT_WIDTH-1:0] long;
        logic [CR_HC_LONG_CNT_WIDTH-1:0] cnt;
        logic [CR_HC_SEQID_WIDTH-1:0]    seq_id;
        logic                            eob;
    } s_sc_is_long_intf;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        COUNT   = 3'd1,
        SCAN    = 3'd2,
        HOLD    = 3'd3,
        EOB_OUT = 3'd4
    } e_sc_long_xmt_st;

endpackage

`default_nettype wire

// File: rtl/cr_huf_comp_sc_long_cnt_ram.sv
// ============================================================================
//  Module      : cr_huf_comp_sc_long_cnt_ram
//  Description : Per-symbol count table, 1R1W, registered read, write-first.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cr_huf_comp_sc_long_cnt_ram #(
    parameter int DEPTH = 576,
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write-first bypass is what keeps back-to-back increments of the same
    // symbol from reading a stale count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            r_rd_data <= wr_data;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/cr_huf_comp_sc_long_xmt.sv
// ============================================================================
//  Module      : cr_huf_comp_sc_long_xmt
//  Description : Counts long-symbol frequencies per block, then streams the
//                nonzero (symbol, count) pairs to the long insertion sort.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cr_huf_comp_sc_long_xmt
    import cr_huf_comp_sc_long_xmt_pkg::*;
#(
    parameter int DAT_WIDTH   = CR_HC_LONG_DAT_WIDTH,
    parameter int CNT_WIDTH   = CR_HC_LONG_CNT_WIDTH,
    parameter int NUM_SYM     = CR_HC_LONG_NUM_SYM,
    parameter int SEQID_WIDTH = CR_HC_SEQID_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sym_vld,
    input  logic [DAT_WIDTH-1:0]   sym,
    input  logic                   blk_end,
    input  logic [SEQID_WIDTH-1:0] blk_seq_id,
    output logic                   sym_rdy,
    input  logic                   is_sc_long_rd,
    output logic                   sc_is_long_vld,
    output s_sc_is_long_intf       sc_is_long_intf,
    output logic                   blk_busy
);

    localparam int                   PW         = DAT_WIDTH + 1;
    localparam logic [PW-1:0]        c_ptr_last = PW'(NUM_SYM - 1);
    localparam logic [PW-1:0]        c_ptr_end  = PW'(NUM_SYM);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;

    e_sc_long_xmt_st        r_state, w_state_nxt;
    logic [PW-1:0]          r_ptr, w_ptr_nxt;

    logic                   r_p_vld;
    logic [DAT_WIDTH-1:0]   r_p_addr;
    logic                   r_s_vld;
    logic [DAT_WIDTH-1:0]   r_s_addr;
    logic                   r_pend_vld;
    logic [DAT_WIDTH-1:0]   r_pend_sym;
    logic [CNT_WIDTH-1:0]   r_pend_cnt;
    logic [SEQID_WIDTH-1:0] r_seq_id;
    s_sc_is_long_intf       r_intf;

    logic                   w_sym_acc;
    logic                   w_hit;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_exhaust;
    logic [DAT_WIDTH-1:0]   w_rd_addr;
    logic [CNT_WIDTH-1:0]   w_rd_data;
    logic                   w_wr_en;
    logic [DAT_WIDTH-1:0]   w_wr_addr;
    logic [CNT_WIDTH-1:0]   w_wr_data;
    logic [CNT_WIDTH-1:0]   w_inc;

    assign w_sym_acc = (r_state == COUNT) && sym_vld && ({1'b0, sym} < c_ptr_end);
    assign w_hit     = r_s_vld && (w_rd_data != '0);
    assign w_inc     = (w_rd_data == c_cnt_max) ? c_cnt_max : w_rd_data + CNT_WIDTH'(1);
    assign w_rd_addr = (r_state == SCAN) ? r_ptr[DAT_WIDTH-1:0] : sym;

    // A found entry is parked in the pending register; it is only pushed to
    // the output once a later nonzero entry appears or the scan runs out,
    // so eob is always known when a pair becomes visible.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        sym_rdy        = 1'b0;
        sc_is_long_vld = 1'b0;
        blk_busy       = 1'b1;
        w_issue        = 1'b0;
        w_push         = 1'b0;
        w_exhaust      = 1'b0;
        case (r_state)
            CLEAR: begin
                w_ptr_nxt = r_ptr + PW'(1);
                if (r_ptr == c_ptr_last) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                sym_rdy  = 1'b1;
                blk_busy = 1'b0;
                if (blk_end) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_hit && r_pend_vld) begin
                    w_push      = 1'b1;
                    w_state_nxt = HOLD;
                end else if (!r_s_vld && (r_ptr == c_ptr_end)) begin
                    w_exhaust   = 1'b1;
                    w_state_nxt = EOB_OUT;
                end else if (r_ptr != c_ptr_end) begin
                    w_issue   = 1'b1;
                    w_ptr_nxt = r_ptr + PW'(1);
                end
            end
            HOLD: begin
                sc_is_long_vld = 1'b1;
                if (is_sc_long_rd) begin
                    w_state_nxt = SCAN;
                end
            end
            EOB_OUT: begin
                sc_is_long_vld = 1'b1;
                if (is_sc_long_rd) begin
                    w_state_nxt = COUNT;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // Clear pass, RMW writeback and clear-on-read never overlap in time.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_p_addr;
        w_wr_data = '0;
        if (r_state == CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ptr[DAT_WIDTH-1:0];
        end else if (r_p_vld) begin
            w_wr_en   = 1'b1;
            w_wr_data = w_inc;
        end else if (r_s_vld) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_s_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_ptr      <= '0;
            r_p_vld    <= 1'b0;
            r_p_addr   <= '0;
            r_s_vld    <= 1'b0;
            r_s_addr   <= '0;
            r_pend_vld <= 1'b0;
            r_pend_sym <= '0;
            r_pend_cnt <= '0;
            r_seq_id   <= '0;
            r_intf     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_p_vld  <= w_sym_acc;
            r_p_addr <= sym;
            r_s_vld  <= w_issue;
            r_s_addr <= r_ptr[DAT_WIDTH-1:0];
            if ((r_state == COUNT) && blk_end) begin
                r_seq_id <= blk_seq_id;
            end
            if (w_hit) begin
                r_pend_vld <= 1'b1;
                r_pend_sym <= r_s_addr;
                r_pend_cnt <= w_rd_data;
            end else if (w_exhaust) begin
                r_pend_vld <= 1'b0;
            end
            if (w_push) begin
                r_intf.long   <= r_pend_sym;
                r_intf.cnt    <= r_pend_cnt;
                r_intf.seq_id <= r_seq_id;
                r_intf.eob    <= 1'b0;
            end else if (w_exhaust) begin
                r_intf.long   <= r_pend_vld ? r_pend_sym : '0;
                r_intf.cnt    <= r_pend_vld ? r_pend_cnt : '0;
                r_intf.seq_id <= r_seq_id;
                r_intf.eob    <= 1'b1;
            end
        end
    end

    assign sc_is_long_intf = r_intf;

    cr_huf_comp_sc_long_cnt_ram #(
        .DEPTH (NUM_SYM),
        .WIDTH (CNT_WIDTH),
        .AW    (DAT_WIDTH)
    ) u_cnt_ram (
        .clk     (clk),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_cr_huf_comp_sc_long_xmt.sv
// ============================================================================
//  Module      : tb_cr_huf_comp_sc_long_xmt
//  Description : Directed + randomized self-checking bench with a frequency
//                table reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cr_huf_comp_sc_long_xmt;
    import cr_huf_comp_sc_long_xmt_pkg::*;

    localparam int NSYM = 576;
    localparam int CMAX = 65535;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sym_vld = 1'b0;
    logic [9:0]       sym = '0;
    logic             blk_end = 1'b0;
    logic [7:0]       blk_seq_id = '0;
    logic             is_sc_long_rd = 1'b0;
    logic             sym_rdy;
    logic             sc_is_long_vld;
    logic             blk_busy;
    s_sc_is_long_intf sc_is_long_intf;

    typedef struct {
        int s;
        int c;
        bit eob;
    } pair_t;

    int    checks = 0;
    int    failures = 0;
    int    ref_cnt [NSYM];
    pair_t exp_q [$];

    cr_huf_comp_sc_long_xmt dut (
        .clk             (clk),
        .rst             (rst),
        .sym_vld         (sym_vld),
        .sym             (sym),
        .blk_end         (blk_end),
        .blk_seq_id      (blk_seq_id),
        .sym_rdy         (sym_rdy),
        .is_sc_long_rd   (is_sc_long_rd),
        .sc_is_long_vld  (sc_is_long_vld),
        .sc_is_long_intf (sc_is_long_intf),
        .blk_busy        (blk_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!sym_rdy && n < 3000) begin
            tick();
            n++;
        end
        if (n == 3000) chk("sym_rdy_wait", sym_rdy, 1);
    endtask

    // One input cycle: optional symbol, optional block close.
    task automatic drive(input bit v, input int s, input bit last, input int seq);
        wait_rdy();
        sym_vld    = v;
        sym        = s[9:0];
        blk_end    = last;
        blk_seq_id = seq[7:0];
        if (v && s < NSYM) ref_cnt[s]++;
        tick();
        sym_vld = 1'b0;
        blk_end = 1'b0;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NSYM; k++) ref_cnt[k] = 0;
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int k = 0; k < NSYM; k++) begin
            if (ref_cnt[k] != 0) exp_q.push_back('{k, (ref_cnt[k] > CMAX) ? CMAX : ref_cnt[k], 1'b0});
        end
        if (exp_q.size() == 0) exp_q.push_back('{0, 0, 1'b0});
        exp_q[exp_q.size()-1].eob = 1'b1;
        clear_model();
    endtask

    // mode 0: rd always high, 1: random rd, 2: rd low for 20 valid cycles first
    task automatic collect(input int seq, input int mode);
        int  i = 0;
        int  cyc = 0;
        int  low = 0;
        bit  held = 1'b0;
        build_exp();
        chk("busy_in_blk", blk_busy, 1);
        chk("rdy_in_blk", sym_rdy, 0);
        while (i < exp_q.size() && cyc < 5000) begin
            case (mode)
                0:       is_sc_long_rd = 1'b1;
                1:       is_sc_long_rd = 1'($urandom % 2);
                default: is_sc_long_rd = (low >= 20);
            endcase
            if (held) chk("vld_held", sc_is_long_vld, 1);
            if (sc_is_long_vld) begin
                chk("long", sc_is_long_intf.long, exp_q[i].s);
                chk("cnt", sc_is_long_intf.cnt, exp_q[i].c);
                chk("seq_id", sc_is_long_intf.seq_id, seq[7:0]);
                chk("eob", sc_is_long_intf.eob, exp_q[i].eob);
                if (!is_sc_long_rd) low++;
                held = !is_sc_long_rd;
                if (is_sc_long_rd) i++;
            end else begin
                held = 1'b0;
            end
            tick();
            cyc++;
        end
        is_sc_long_rd = 1'b0;
        chk("pairs_done", i, exp_q.size());
        chk("vld_after_eob", sc_is_long_vld, 0);
        chk("busy_after_eob", blk_busy, 0);
        chk("rdy_after_eob", sym_rdy, 1);
    endtask

    initial begin
        int  n;
        int  nb;
        int  sq;
        int  s;
        bit  ended;

        clear_model();
        #1;
        chk("rst_sym_rdy", sym_rdy, 0);
        chk("rst_vld", sc_is_long_vld, 0);
        chk("rst_intf", sc_is_long_intf, 0);
        chk("rst_busy", blk_busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (!sym_rdy && n < 2000) begin
            tick();
            n++;
        end
        chk("clear_cycles", n, NSYM);

        // 3,3,7 -> (3,2),(7,1)
        drive(1, 3, 0, 5);
        drive(1, 3, 0, 5);
        drive(1, 7, 0, 5);
        drive(0, 0, 1, 5);
        collect(5, 0);

        // empty block
        drive(0, 0, 1, 2);
        collect(2, 0);

        // saturation
        wait_rdy();
        sym_vld = 1'b1;
        sym     = 10'd9;
        for (int k = 0; k < CMAX + 5; k++) tick();
        sym_vld = 1'b0;
        ref_cnt[9] = CMAX + 5;
        drive(0, 0, 1, 7);
        collect(7, 1);

        // long stall on the output, then a fresh block must count from zero
        drive(1, 1, 0, 9);
        drive(1, 2, 0, 9);
        drive(1, 1, 0, 9);
        drive(0, 0, 1, 9);
        collect(9, 2);
        drive(1, 1, 0, 10);
        drive(0, 0, 1, 10);
        collect(10, 0);

        // table edges, out-of-range symbol, close coincident with a symbol
        drive(1, 0, 0, 11);
        drive(1, 600, 0, 11);
        drive(1, NSYM - 1, 1, 11);
        collect(11, 0);

        // randomized blocks
        for (int b = 0; b < 5; b++) begin
            nb    = $urandom_range(0, 60);
            sq    = $urandom_range(0, 255);
            ended = 1'b0;
            for (int k = 0; k < nb; k++) begin
                s = ($urandom % 2 == 1) ? $urandom_range(0, 7) : $urandom_range(0, 639);
                if ($urandom % 4 == 0) tick();
                ended = (k == nb - 1) && ($urandom % 2 == 1);
                drive(1, s, ended, sq);
            end
            if (!ended) drive(0, 0, 1, sq);
            collect(sq, 1);
        end

        // async reset while a pair is held
        drive(1, 5, 0, 12);
        drive(1, 6, 0, 12);
        drive(0, 0, 1, 12);
        n = 0;
        while (!sc_is_long_vld && n < 2000) begin
            tick();
            n++;
        end
        chk("hold_reached", sc_is_long_vld, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_vld", sc_is_long_vld, 0);
        chk("rst_async_busy", blk_busy, 1);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (!sym_rdy && n < 2000) begin
            tick();
            n++;
        end
        chk("reclear_cycles", n, NSYM);
        drive(1, 4, 0, 13);
        drive(0, 0, 1, 13);
        collect(13, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
